// File: rtl/button_event_ctrl.sv
// button_event_ctrl: debounced button levels to a queued PRESS/RELEASE/LONG/REPEAT event stream.
// Define BTN_EVT_REPEAT_EN to build the REPEAT timer in the HELD state.
module button_event_ctrl #(
  parameter int N_BTN         = 4,
  parameter int LONG_CYCLES   = 62500000,
  parameter int REPEAT_CYCLES = 25000000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         btn_db,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_btn,
  output logic [1:0]               evt_type,
  output logic                     ovf,
  input  logic                     ovf_clr
);
  localparam int BW = $clog2(N_BTN);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2((LONG_CYCLES > REPEAT_CYCLES ? LONG_CYCLES : REPEAT_CYCLES) + 1);
  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;
  typedef enum logic [1:0] {E_PRESS, E_RELEASE, E_LONG, E_REPEAT} evt_t;
  state_t         state_q [N_BTN];
  state_t         state_d [N_BTN];
  logic [TW-1:0]  timer_q [N_BTN];
  logic [TW-1:0]  timer_d [N_BTN];
  evt_t           ev_t    [N_BTN];
  evt_t           pend_t  [N_BTN];
  logic [N_BTN-1:0] ev_v, pend_v, gnt_oh, drop;
  logic [BW-1:0]  rr_ptr, gnt_idx, cand;
  logic           any_pend, grant, pop, can_push;
  logic [BW+1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      ev_v[i]    = 1'b0;
      ev_t[i]    = E_PRESS;
      case (state_q[i])
        IDLE: if (btn_db[i]) begin
          ev_v[i]    = 1'b1;
          timer_d[i] = TW'(1);
          state_d[i] = PRESSED;
        end
        PRESSED: if (!btn_db[i]) begin
          ev_v[i]    = 1'b1;
          ev_t[i]    = E_RELEASE;
          timer_d[i] = '0;
          state_d[i] = IDLE;
        end else if (timer_q[i] == TW'(LONG_CYCLES)) begin
          ev_v[i]    = 1'b1;
          ev_t[i]    = E_LONG;
          timer_d[i] = TW'(1);
          state_d[i] = HELD;
        end else begin
          timer_d[i] = (timer_q[i] == '1) ? timer_q[i] : timer_q[i] + 1'b1;
        end
        HELD: if (!btn_db[i]) begin
          ev_v[i]    = 1'b1;
          ev_t[i]    = E_RELEASE;
          timer_d[i] = '0;
          state_d[i] = IDLE;
        end
`ifdef BTN_EVT_REPEAT_EN
        else if (timer_q[i] == TW'(REPEAT_CYCLES)) begin
          ev_v[i]    = 1'b1;
          ev_t[i]    = E_REPEAT;
          timer_d[i] = TW'(1);
        end else begin
          timer_d[i] = (timer_q[i] == '1) ? timer_q[i] : timer_q[i] + 1'b1;
        end
`else
        else begin
          timer_d[i] = timer_q[i];
        end
`endif
        default: state_d[i] = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end
  assign pop      = evt_valid & evt_ready;
  assign can_push = (count != (AW+1)'(FIFO_DEPTH)) | pop;
  // scan downward so the lowest offset from rr_ptr wins
  always_comb begin
    any_pend = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      cand = BW'((int'(rr_ptr) + k) % N_BTN);
      if (pend_v[cand]) begin
        any_pend = 1'b1;
        gnt_idx  = cand;
      end
    end
    grant = any_pend & can_push;
    for (int i = 0; i < N_BTN; i++) begin
      gnt_oh[i] = grant && (gnt_idx == BW'(i));
      drop[i]   = ev_v[i] && pend_v[i] && !gnt_oh[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v <= '0;
      for (int i = 0; i < N_BTN; i++) pend_t[i] <= E_PRESS;
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (ev_v[i] && (!pend_v[i] || gnt_oh[i])) begin
          pend_v[i] <= 1'b1;
          pend_t[i] <= ev_t[i];
        end else if (gnt_oh[i]) begin
          pend_v[i] <= 1'b0;
        end
      end
      if (grant) begin
        rr_ptr <= BW'((int'(gnt_idx) + 1) % N_BTN);
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(grant) - (AW+1)'(pop);
      ovf   <= (|drop) | (ovf & ~ovf_clr);
    end
  end
  always_ff @(posedge clk) begin
    if (grant) mem[wr_ptr] <= {gnt_idx, pend_t[gnt_idx]};
  end
  assign evt_valid = (count != '0);
  assign evt_btn   = evt_valid ? mem[rd_ptr][BW+1:2] : '0;
  assign evt_type  = evt_valid ? mem[rd_ptr][1:0] : 2'd0;
endmodule
